// File: rtl/hazard_scoreboard_unit_if.sv
// Hazard unit bundle: register indices and control bits from the datapath,
// plus the forward selects, stalls and flushes returned to it.
// master = datapath side, slave = hazard_scoreboard_unit.
interface hazard_scoreboard_unit_if #(
    parameter int REG_W      = 5,
    parameter int FWD_STAGES = 3
);
    localparam int FSEL_W = $clog2(FWD_STAGES + 1);

    logic [REG_W-1:0]            rs1_d;
    logic [REG_W-1:0]            rs2_d;
    logic [REG_W-1:0]            rs1_e;
    logic [REG_W-1:0]            rs2_e;
    logic [REG_W-1:0]            rd_e;
    logic                        load_e;
    logic [FWD_STAGES-1:0]       regwrite_stage;
    logic [FWD_STAGES-1:0]       load_stage;
    logic [FWD_STAGES*REG_W-1:0] rd_stage;
    logic                        mc_issue_e;
    logic                        mc_done;
    logic                        mispredict;
    logic                        flushflag;

    logic [FSEL_W-1:0]           forwarda_e;
    logic [FSEL_W-1:0]           forwardb_e;
    logic                        stall_f;
    logic                        stall_d;
    logic                        flush_d;
    logic                        flush_e;
    logic [FWD_STAGES-1:0]       flush_stage;
    logic                        mc_kill;
    logic                        mc_busy;
    logic [4:0]                  hazard_cause;

    modport master (
        output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, load_e, regwrite_stage,
               load_stage, rd_stage, mc_issue_e, mc_done, mispredict, flushflag,
        input  forwarda_e, forwardb_e, stall_f, stall_d, flush_d, flush_e,
               flush_stage, mc_kill, mc_busy, hazard_cause
    );

    modport slave (
        input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, load_e, regwrite_stage,
               load_stage, rd_stage, mc_issue_e, mc_done, mispredict, flushflag,
        output forwarda_e, forwardb_e, stall_f, stall_d, flush_d, flush_e,
               flush_stage, mc_kill, mc_busy, hazard_cause
    );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// Hazard controller for the in-order pipeline: generalised forwarding over
// FWD_STAGES post-execute stages, load-use detection, and an in-order
// scoreboard of outstanding multi-cycle writebacks.
// Optional: define HAZARD_PERF_EN to add saturating stall/flush/mc-wait counters.
module hazard_scoreboard_unit #(
    parameter int REG_W      = 5,
    parameter int FWD_STAGES = 3,
    parameter int LOAD_READY = 2,
    parameter int MC_DEPTH   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    hazard_scoreboard_unit_if.slave  hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]              perf_stall_cnt,
    output logic [31:0]              perf_flush_cnt,
    output logic [31:0]              perf_mc_wait_cnt
`endif
);
    localparam int FSEL_W = $clog2(FWD_STAGES + 1);
    localparam int PTR_W  = (MC_DEPTH > 1) ? $clog2(MC_DEPTH) : 1;
    localparam int CNT_W  = $clog2(MC_DEPTH + 1);

    // A source depends on a destination only when it names a real register.
    function automatic logic src_hit(input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rd);
        return (rs != '0) && (rs == rd);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MC_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [MC_DEPTH-1:0] ent_valid_q, ent_valid_d;
    logic [REG_W-1:0]    ent_rd_q [MC_DEPTH];
    logic [REG_W-1:0]    ent_rd_d [MC_DEPTH];
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                mc_busy_q, mc_busy_d;
    logic                mc_kill_q, mc_kill_d;

    logic [FSEL_W-1:0]   fwd_a, fwd_b;
    logic                load_use, mc_raw, mc_struct, mc_full;
    logic                flush_front, stall_dec, pop, push;

    // Forward selects: scan oldest to youngest so the youngest eligible stage wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        fwd_a = '0;
        fwd_b = '0;
        for (int i = FWD_STAGES - 1; i >= 0; i--) begin
            if (hz.regwrite_stage[i] && (!hz.load_stage[i] || i >= LOAD_READY)) begin
                if (src_hit(hz.rs1_e, hz.rd_stage[i*REG_W +: REG_W])) fwd_a = FSEL_W'(i + 1);
                if (src_hit(hz.rs2_e, hz.rd_stage[i*REG_W +: REG_W])) fwd_b = FSEL_W'(i + 1);
            end
        end
    end

    // Hazard detection: load-use against E and early post-E stages, plus scoreboard RAW/full.
    always_comb begin
        load_use = hz.load_e && (src_hit(hz.rs1_d, hz.rd_e) || src_hit(hz.rs2_d, hz.rd_e));
        for (int i = 0; i < FWD_STAGES; i++) begin
            if (i < LOAD_READY - 1 && hz.load_stage[i] &&
                (src_hit(hz.rs1_d, hz.rd_stage[i*REG_W +: REG_W]) ||
                 src_hit(hz.rs2_d, hz.rd_stage[i*REG_W +: REG_W])))
                load_use = 1'b1;
        end
        mc_raw = 1'b0;
        for (int j = 0; j < MC_DEPTH; j++) begin
            if (ent_valid_q[j] && (src_hit(hz.rs1_d, ent_rd_q[j]) || src_hit(hz.rs2_d, ent_rd_q[j])))
                mc_raw = 1'b1;
        end
        mc_full     = (count_q == CNT_W'(MC_DEPTH));
        mc_struct   = mc_full && hz.mc_issue_e;
        flush_front = hz.flushflag || hz.mispredict;
        stall_dec   = (load_use || mc_raw || mc_struct) && !flush_front;
    end

    assign hz.forwarda_e   = fwd_a;
    assign hz.forwardb_e   = fwd_b;
    assign hz.stall_f      = stall_dec;
    assign hz.stall_d      = stall_dec;
    assign hz.flush_d      = flush_front;
    assign hz.flush_e      = flush_front || load_use || mc_raw || mc_struct;
    assign hz.flush_stage  = {{(FWD_STAGES-1){hz.flushflag}}, flush_front};
    assign hz.mc_kill      = mc_kill_q;
    assign hz.mc_busy      = mc_busy_q;
    assign hz.hazard_cause = {mc_struct, mc_raw, hz.mispredict, load_use, (fwd_a != '0) || (fwd_b != '0)};

    // Scoreboard next state: trap flush wins, otherwise pop the head then push at the tail.
    always_comb begin
        ent_valid_d = ent_valid_q;
        ent_rd_d    = ent_rd_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        pop         = hz.mc_done && (count_q != '0);
        // A full scoreboard can only accept an issue in the cycle its head retires.
        push        = hz.mc_issue_e && (!mc_full || pop);
        count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
        if (hz.flushflag) begin
            ent_valid_d = '0;
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
        end else begin
            if (pop) begin
                ent_valid_d[rd_ptr_q] = 1'b0;
                rd_ptr_d              = ptr_inc(rd_ptr_q);
            end
            if (push) begin
                ent_valid_d[wr_ptr_q] = 1'b1;
                ent_rd_d[wr_ptr_q]    = hz.rd_e;
                wr_ptr_d              = ptr_inc(wr_ptr_q);
            end
        end
        mc_busy_d = (count_d != '0);
        mc_kill_d = hz.flushflag;
    end

    // Scoreboard and registered status flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_valid_q <= '0;
            // NOTE: the rd array is tiny and is compared against decode sources, so it is reset too rather than left X.
            for (int j = 0; j < MC_DEPTH; j++) ent_rd_q[j] <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            mc_busy_q <= 1'b0;
            mc_kill_q <= 1'b0;
        end else begin
            // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
            ent_valid_q <= ent_valid_d;
            ent_rd_q    <= ent_rd_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            mc_busy_q   <= mc_busy_d;
            mc_kill_q   <= mc_kill_d;
        end
    end

`ifndef SYNTHESIS
    // Retiring from an empty scoreboard means the multi-cycle unit and pipeline disagree.
    pop_empty_a: assert property (@(posedge clk) disable iff (!rst_n) !(hz.mc_done && count_q == '0));
`endif

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;
    logic [31:0] perf_mc_wait_q, perf_mc_wait_d;

    // Saturating event counters.
    always_comb begin
        perf_stall_d   = (stall_dec && perf_stall_q != '1) ? perf_stall_q + 32'd1 : perf_stall_q;
        perf_flush_d   = (flush_front && perf_flush_q != '1) ? perf_flush_q + 32'd1 : perf_flush_q;
        perf_mc_wait_d = ((mc_raw || mc_struct) && perf_mc_wait_q != '1) ? perf_mc_wait_q + 32'd1
                                                                          : perf_mc_wait_q;
    end

    // Counter flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q   <= '0;
            perf_flush_q   <= '0;
            perf_mc_wait_q <= '0;
        end else begin
            perf_stall_q   <= perf_stall_d;
            perf_flush_q   <= perf_flush_d;
            perf_mc_wait_q <= perf_mc_wait_d;
        end
    end

    assign perf_stall_cnt   = perf_stall_q;
    assign perf_flush_cnt   = perf_flush_q;
    assign perf_mc_wait_cnt = perf_mc_wait_q;
`endif
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Self-checking bench for hazard_scoreboard_unit (default parameters).
// Each vector's expected outputs are queued when the stimulus is driven and
// popped for comparison when the outputs are sampled on the falling edge.
module tb_hazard_scoreboard_unit;
    localparam int REG_W = 5;
    localparam int FWD   = 3;

    typedef struct {
        logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
        logic        load_e;
        logic [2:0]  regwrite_stage, load_stage;
        logic [14:0] rd_stage;
        logic        mc_issue_e, mc_done, mispredict, flushflag;
    } stim_t;

    typedef struct {
        string      tag;
        logic [1:0] fwda, fwdb;
        logic       stall, flush_d, flush_e;
        logic [2:0] flush_stage;
        logic       kill, busy;
        logic [4:0] cause;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t exp_q[$];

    hazard_scoreboard_unit_if #(.REG_W(REG_W), .FWD_STAGES(FWD)) hz_if ();

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_mc_wait_cnt;
    hazard_scoreboard_unit #(.REG_W(REG_W), .FWD_STAGES(FWD), .LOAD_READY(2), .MC_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .hz(hz_if),
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
        .perf_mc_wait_cnt(perf_mc_wait_cnt)
    );
`else
    hazard_scoreboard_unit #(.REG_W(REG_W), .FWD_STAGES(FWD), .LOAD_READY(2), .MC_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .hz(hz_if)
    );
`endif

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.rs1_d = '0; s.rs2_d = '0; s.rs1_e = '0; s.rs2_e = '0; s.rd_e = '0;
        s.load_e = 1'b0; s.regwrite_stage = '0; s.load_stage = '0; s.rd_stage = '0;
        s.mc_issue_e = 1'b0; s.mc_done = 1'b0; s.mispredict = 1'b0; s.flushflag = 1'b0;
        return s;
    endfunction

    function automatic logic [14:0] rdst(input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] s2);
        return {s2, s1, s0};
    endfunction

    function automatic exp_t ex(input logic [1:0] fwda, input logic [1:0] fwdb, input logic stall,
                                input logic flush_d, input logic flush_e, input logic [2:0] flush_stage,
                                input logic kill, input logic busy, input logic [4:0] cause);
        exp_t e;
        e.tag = ""; e.fwda = fwda; e.fwdb = fwdb; e.stall = stall; e.flush_d = flush_d;
        e.flush_e = flush_e; e.flush_stage = flush_stage; e.kill = kill; e.busy = busy; e.cause = cause;
        return e;
    endfunction

    task automatic drive(input stim_t s);
        hz_if.rs1_d = s.rs1_d; hz_if.rs2_d = s.rs2_d;
        hz_if.rs1_e = s.rs1_e; hz_if.rs2_e = s.rs2_e; hz_if.rd_e = s.rd_e;
        hz_if.load_e = s.load_e; hz_if.regwrite_stage = s.regwrite_stage;
        hz_if.load_stage = s.load_stage; hz_if.rd_stage = s.rd_stage;
        hz_if.mc_issue_e = s.mc_issue_e; hz_if.mc_done = s.mc_done;
        hz_if.mispredict = s.mispredict; hz_if.flushflag = s.flushflag;
    endtask

    // Pop the oldest expectation and compare every output against it.
    task automatic compare_out();
        exp_t e;
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        check({e.tag, ".fwda"},    32'(hz_if.forwarda_e),   32'(e.fwda));
        check({e.tag, ".fwdb"},    32'(hz_if.forwardb_e),   32'(e.fwdb));
        check({e.tag, ".stall_f"}, 32'(hz_if.stall_f),      32'(e.stall));
        check({e.tag, ".stall_d"}, 32'(hz_if.stall_d),      32'(e.stall));
        check({e.tag, ".flush_d"}, 32'(hz_if.flush_d),      32'(e.flush_d));
        check({e.tag, ".flush_e"}, 32'(hz_if.flush_e),      32'(e.flush_e));
        check({e.tag, ".flush_st"},32'(hz_if.flush_stage),  32'(e.flush_stage));
        check({e.tag, ".mc_kill"}, 32'(hz_if.mc_kill),      32'(e.kill));
        check({e.tag, ".mc_busy"}, 32'(hz_if.mc_busy),      32'(e.busy));
        check({e.tag, ".cause"},   32'(hz_if.hazard_cause), 32'(e.cause));
    endtask

    task automatic expect_now(input string tag, input exp_t e);
        e.tag = tag;
        exp_q.push_back(e);
        compare_out();
    endtask

    // One pipeline cycle: drive after the rising edge, sample on the falling edge.
    task automatic step(input string tag, input stim_t s, input exp_t e);
        @(posedge clk);
        #1;
        drive(s);
        e.tag = tag;
        exp_q.push_back(e);
        @(negedge clk);
        compare_out();
    endtask

    stim_t s;

    initial begin
        drive(idle());
        repeat (2) @(posedge clk);
        @(negedge clk);
        expect_now("reset", ex(0, 0, 0, 0, 0, 3'b000, 0, 0, 5'b00000));
        rst_n = 1'b1;

        s = idle();                                               step("idle", s, ex(0,0,0,0,0,3'b000,0,0,5'b00000));

        // Forwarding priority and gating
        s = idle(); s.regwrite_stage = 3'b101; s.rd_stage = rdst(5,0,5); s.rs1_e = 5;
        step("fwd_s0", s, ex(1,0,0,0,0,3'b000,0,0,5'b00001));
        s.regwrite_stage = 3'b100;
        step("fwd_s2", s, ex(3,0,0,0,0,3'b000,0,0,5'b00001));
        s.regwrite_stage = 3'b101; s.rs1_e = 0; s.rs2_e = 5;
        step("fwd_x0", s, ex(0,1,0,0,0,3'b000,0,0,5'b00001));
        s = idle(); s.regwrite_stage = 3'b011; s.load_stage = 3'b011; s.rd_stage = rdst(6,6,0); s.rs1_e = 6;
        step("fwd_ld_gate", s, ex(0,0,0,0,0,3'b000,0,0,5'b00000));
        s.regwrite_stage = 3'b111; s.load_stage = 3'b111; s.rd_stage = rdst(6,6,6); s.rs2_e = 6;
        step("fwd_ld_w", s, ex(3,3,0,0,0,3'b000,0,0,5'b00001));

        // Load-use
        s = idle(); s.load_e = 1; s.rd_e = 7; s.rs2_d = 7;
        step("ld_use_e", s, ex(0,0,1,0,1,3'b000,0,0,5'b00010));
        s = idle(); s.rs2_d = 7;
        step("ld_use_clr", s, ex(0,0,0,0,0,3'b000,0,0,5'b00000));
        s = idle(); s.load_stage = 3'b001; s.rd_stage = rdst(8,0,0); s.rs1_d = 8;
        step("ld_use_m1", s, ex(0,0,1,0,1,3'b000,0,0,5'b00010));
        s = idle(); s.load_stage = 3'b010; s.rd_stage = rdst(0,8,0); s.rs1_d = 8;
        step("ld_m2_ok", s, ex(0,0,0,0,0,3'b000,0,0,5'b00000));
        s = idle(); s.load_e = 1; s.rd_e = 0;
        step("ld_x0", s, ex(0,0,0,0,0,3'b000,0,0,5'b00000));
        s = idle(); s.mispredict = 1; s.load_e = 1; s.rd_e = 7; s.rs1_d = 7;
        step("mp_ld", s, ex(0,0,0,1,1,3'b001,0,0,5'b00110));

        // Multi-cycle RAW until completion
        s = idle(); s.mc_issue_e = 1; s.rd_e = 9;
        step("mc_issue9", s, ex(0,0,0,0,0,3'b000,0,0,5'b00000));
        s = idle(); s.rs1_d = 9;
        for (int k = 0; k < 3; k++) step("mc_raw", s, ex(0,0,1,0,1,3'b000,0,1,5'b01000));
        s.mc_done = 1;
        step("mc_raw_done", s, ex(0,0,1,0,1,3'b000,0,1,5'b01000));
        s.mc_done = 0;
        step("mc_clear", s, ex(0,0,0,0,0,3'b000,0,0,5'b00000));

        // Structural full, simultaneous retire and issue
        s = idle(); s.mc_issue_e = 1; s.rd_e = 3;
        step("mc_issue3", s, ex(0,0,0,0,0,3'b000,0,0,5'b00000));
        s.rd_e = 4;
        step("mc_issue4", s, ex(0,0,0,0,0,3'b000,0,1,5'b00000));
        s.rd_e = 5;
        step("mc_struct", s, ex(0,0,1,0,1,3'b000,0,1,5'b10000));
        s.mc_done = 1;
        step("mc_swap", s, ex(0,0,1,0,1,3'b000,0,1,5'b10000));
        s = idle(); s.rs1_d = 3;
        step("mc_pop3", s, ex(0,0,0,0,0,3'b000,0,1,5'b00000));
        s = idle(); s.rs2_d = 5;
        step("mc_has5", s, ex(0,0,1,0,1,3'b000,0,1,5'b01000));
        s = idle(); s.mc_issue_e = 1; s.rd_e = 0; s.rs1_d = 4;
        step("mc_full", s, ex(0,0,1,0,1,3'b000,0,1,5'b11000));

        // Trap flush clears scoreboard, pulses kill
        s = idle(); s.flushflag = 1; s.rs1_d = 4; s.mc_issue_e = 1; s.rd_e = 6;
        step("flush", s, ex(0,0,0,1,1,3'b111,0,1,5'b11000));
        s = idle(); s.rs1_d = 4;
        step("kill", s, ex(0,0,0,0,0,3'b000,1,0,5'b00000));
        s = idle();
        step("kill_end", s, ex(0,0,0,0,0,3'b000,0,0,5'b00000));
        s = idle(); s.mispredict = 1;
        step("mispredict", s, ex(0,0,0,1,1,3'b001,0,0,5'b00100));
        s = idle(); s.flushflag = 1; s.mc_issue_e = 1; s.rd_e = 6;
        step("flush_issue", s, ex(0,0,0,1,1,3'b111,0,0,5'b00000));
        s = idle(); s.rs1_d = 6;
        step("flush_drop", s, ex(0,0,0,0,0,3'b000,1,0,5'b00000));

        // Asynchronous reset with two outstanding entries
        s = idle(); s.mc_issue_e = 1; s.rd_e = 3;
        step("rst_issue3", s, ex(0,0,0,0,0,3'b000,0,0,5'b00000));
        s.rd_e = 4;
        step("rst_issue4", s, ex(0,0,0,0,0,3'b000,0,1,5'b00000));
        s = idle(); s.rs1_d = 3;
        step("rst_pre", s, ex(0,0,1,0,1,3'b000,0,1,5'b01000));
        #2 rst_n = 1'b0;
        #1 expect_now("rst_async", ex(0,0,0,0,0,3'b000,0,0,5'b00000));
`ifdef HAZARD_PERF_EN
        check("perf_stall_rst",   perf_stall_cnt,   32'd0);
        check("perf_flush_rst",   perf_flush_cnt,   32'd0);
        check("perf_mc_wait_rst", perf_mc_wait_cnt, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step("rst_after", s, ex(0,0,0,0,0,3'b000,0,0,5'b00000));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
- Next-generation hazard controller for the in-order RISC-V pipeline.
- Generalises the fixed M1/M2/W forwarding and load-use logic to FWD_STAGES post-execute stages.
- Adds a registered scoreboard that tracks outstanding multi-cycle (mul/div) writebacks and stalls decode on dependencies and on structural full.
- Sits beside the datapath: consumes register indices and control bits, and drives forward selects, stalls and flushes.

Parameters:
REG_W, 5, register index width
FWD_STAGES, 3, post-E stages able to forward; index 0 = youngest (M1), FWD_STAGES-1 = W
LOAD_READY, 2, first stage index at which load data is forwardable (M2 = 1 counts from 0, so 2 means W)
MC_DEPTH, 2, outstanding multi-cycle ops tracked (power of 2, >=1)

Ports:
clk  in  1  core clock
rst_n  in  1  async active-low reset
rs1_d, rs2_d  in  REG_W  decode source regs
rs1_e, rs2_e  in  REG_W  execute source regs
rd_e  in  REG_W  execute dest
load_e  in  1  load in E
regwrite_stage  in  FWD_STAGES  per-stage write enable
load_stage  in  FWD_STAGES  per-stage load flag
rd_stage  in  FWD_STAGES*REG_W  per-stage dest, stage i at [i*REG_W +: REG_W]
mc_issue_e  in  1  multi-cycle op leaves E this cycle
mc_done  in  1  multi-cycle unit writes back oldest op this cycle
mispredict  in  1  branch mispredict resolved in E
flushflag  in  1  trap/interrupt flush
forwarda_e, forwardb_e  out  $clog2(FWD_STAGES+1)  0 = regfile, i+1 = stage i
stall_f, stall_d  out  1  hold PC / IF-ID
flush_d, flush_e  out  1  bubble ID / EX
flush_stage  out  FWD_STAGES  bubble per post-E stage
mc_kill  out  1  abort multi-cycle unit
mc_busy  out  1  scoreboard non-empty
hazard_cause  out  5  {mc_struct, mc_raw, mispredict, load_use, raw_data}

Behaviour:
- Reset (async, rst_n low):
  - Scoreboard empty; read/write pointers 0; count 0.
  - Registered outputs: mc_busy=0, mc_kill=0.
  - All other outputs are combinational from inputs and state. With inputs idle they evaluate to 0.
- Forwarding:
  - For srcA, select the lowest i with regwrite_stage[i], rd_stage[i]==rs1_e, rs1_e!=0, and (!load_stage[i] or i>=LOAD_READY).
  - forwarda_e = i+1; if no stage matches, 0. srcB is identical using rs2_e.
  - raw_data = any non-zero select.
- Load-use: asserted when rs1_d or rs2_d is non-zero and either:
  - matches rd_e with load_e set, or
  - matches rd_stage[i] with load_stage[i] set, for i<LOAD_READY-1.
- Scoreboard:
  - FIFO of MC_DEPTH entries {valid, rd}.
  - mc_issue_e pushes rd_e at the write pointer.
  - mc_done pops the head; completion is in-order.
  - Push and pop in the same cycle leave count unchanged.
  - Pop while empty is ignored; this is an assertion error in simulation.
- mc_raw: rs1_d/rs2_d non-zero and equal to any valid entry's rd.
  - The popped entry is already invalid in the cycle after mc_done.
  - The result is then forwarded from the W stage through the normal path.
- mc_struct: count==MC_DEPTH while the decode instruction is a multi-cycle op.
  - mc_struct is approximated by stalling whenever the count is full and mc_issue_e would push. stall_d covers this.
- Stall and flush equations:
  - stall_f = stall_d = (load_use | mc_raw | mc_struct) & !flush_d
  - flush_e = flushflag | mispredict | load_use | mc_raw | mc_struct
  - flush_d = flushflag | mispredict
  - flush_stage[0] = flushflag | mispredict
  - flush_stage[i>0] = flushflag
- Flush priority:
  - flushflag clears all scoreboard entries at the next edge.
  - mc_kill is pulsed high for 1 cycle after that edge.
  - A simultaneous mc_issue_e is discarded.
  - mispredict does not touch the scoreboard; the branch is in E, so no concurrent issue is possible.
- x0 never creates a dependency.
- Pointer wrap is modulo MC_DEPTH.

Optional Feature:
HAZARD_PERF_EN
- Defined: adds 32-bit saturating counters perf_stall_cnt, perf_flush_cnt, perf_mc_wait_cnt as outputs.
  - perf_stall_cnt increments per cycle with stall_d=1.
  - perf_flush_cnt increments per cycle with flush_d=1.
  - perf_mc_wait_cnt increments per cycle with mc_raw|mc_struct.
  - Counters reset to 0 with rst_n and saturate at 0xFFFF_FFFF.
- Undefined: ports and logic are absent.

Test Plan:
- Stage 0 and stage 2 both write x5, rs1_e=5, no loads -> forwarda_e=1.
  - Clear stage 0 -> forwarda_e=3.
  - rs1_e=0 -> forwarda_e=0.
- load_e=1, rd_e=7, rs2_d=7 -> stall_f=stall_d=flush_e=1 for 1 cycle; hazard_cause=5'b00010.
- mc_issue_e rd_e=9, then rs1_d=9 held -> stall_d=1 every cycle until mc_done.
  - Cycle after mc_done -> stall_d=0, mc_busy=0.
- MC_DEPTH=2: issue rd=3, then rd=4; third mc op in decode -> mc_struct stall.
  - mc_done and mc_issue_e in the same cycle -> count stays 2.
- Two entries valid, then flushflag=1 -> next cycle mc_busy=0 and mc_kill=1 for exactly 1 cycle.
  - All flushes assert and stall_d=0.
- rst_n low mid-operation with 2 entries -> mc_busy=0 immediately (async); no stall after release.
  - With HAZARD_PERF_EN, counters also read 0.
